// File: rtl/display_req_queue.sv
// Request FIFO for the formatted-display unit. It dispatches queued requests one at a
// time over the display_en / display_busy handshake and flags unacknowledged ones.
module display_req_queue #(
  parameter int DATA_W      = 32,
  parameter int FMT_W       = 2,
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [DATA_W-1:0]        req_data,
  input  logic [FMT_W-1:0]         req_fmt,
  output logic [DATA_W-1:0]        data_in,
  output logic [FMT_W-1:0]         format_sel,
  output logic                     display_en,
  input  logic                     display_busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              issued_cnt,
  output logic                     timeout_err
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int TW    = $clog2(ACK_TIMEOUT + 1);
  localparam int ENT_W = FMT_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  logic [ENT_W-1:0]  mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [LW-1:0]     level_r;
  logic [LW-1:0]     level_next_s;
  logic              ready_r;
  state_t            state_r;
  logic [TW-1:0]     ack_cnt_r;
  logic [DATA_W-1:0] data_r;
  logic [FMT_W-1:0]  fmt_r;
  logic              en_r;
  logic [15:0]       issued_cnt_r;
  logic              timeout_err_r;
  logic              push_s;
  logic              pop_s;

  // A push is gated only by the registered ready, so a same-cycle pop never frees a full slot.
  assign push_s = req_valid && ready_r;
  assign pop_s  = (state_r == IDLE) && (level_r != LW'(0));

  // Next occupancy from the push/pop pair.
  always_comb begin
    level_next_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_next_s = level_r + LW'(1);
      2'b01:   level_next_s = level_r - LW'(1);
      default: level_next_s = level_r;
    endcase
  end

  // Request storage; the contents need no reset because the pointers and level guard every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {req_fmt, req_data};
    end
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level_r  <= LW'(0);
      ready_r  <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r <= level_next_s;
      ready_r <= (level_next_s != LW'(DEPTH));
    end
  end

  // Dispatch FSM: one request in flight, outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      ack_cnt_r     <= TW'(0);
      data_r        <= DATA_W'(0);
      fmt_r         <= FMT_W'(0);
      en_r          <= 1'b0;
      issued_cnt_r  <= 16'd0;
      timeout_err_r <= 1'b0;
    end else begin
      en_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            {fmt_r, data_r} <= mem_r[rd_ptr_r];
            en_r            <= 1'b1;
            state_r         <= ISSUE;
          end
        end
        ISSUE: begin
          issued_cnt_r <= issued_cnt_r + 16'd1;
          ack_cnt_r    <= TW'(0);
          state_r      <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (display_busy) begin
            state_r <= WAIT_DONE;
          end else if (ack_cnt_r == TW'(ACK_TIMEOUT - 1)) begin
            timeout_err_r <= 1'b1;
            state_r       <= IDLE;
          end else begin
            ack_cnt_r <= ack_cnt_r + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!display_busy) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign req_ready   = ready_r;
  assign level       = level_r;
  assign data_in     = data_r;
  assign format_sel  = fmt_r;
  assign display_en  = en_r;
  assign issued_cnt  = issued_cnt_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_display_req_queue.sv
// Directed bench for display_req_queue. A queue scoreboard records accepted requests and
// matches them against each display_en pulse.
module tb_display_req_queue;
  localparam int DATA_W      = 32;
  localparam int FMT_W       = 2;
  localparam int DEPTH       = 4;
  localparam int ACK_TIMEOUT = 16;

  logic                   clk;
  logic                   rst;
  logic                   req_valid;
  logic                   req_ready;
  logic [DATA_W-1:0]      req_data;
  logic [FMT_W-1:0]       req_fmt;
  logic [DATA_W-1:0]      data_in;
  logic [FMT_W-1:0]       format_sel;
  logic                   display_en;
  logic                   display_busy;
  logic [$clog2(DEPTH):0] level;
  logic [15:0]            issued_cnt;
  logic                   timeout_err;

  int checks = 0;
  int errors = 0;
  logic [FMT_W+DATA_W-1:0] exp_q[$];
  logic prev_en = 1'b0;
  logic [DATA_W-1:0] t3_data [3];
  logic [FMT_W-1:0]  t3_fmt  [3];
  logic en_seen;

  display_req_queue #(
    .DATA_W(DATA_W), .FMT_W(FMT_W), .DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_fmt(req_fmt), .data_in(data_in), .format_sel(format_sel),
    .display_en(display_en), .display_busy(display_busy), .level(level),
    .issued_cnt(issued_cnt), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle: record the accepted push, then match any display pulse against the scoreboard.
  task automatic tick();
    logic [FMT_W+DATA_W-1:0] ent;
    if (rst) exp_q.delete();
    else if (req_valid && req_ready) exp_q.push_back({req_fmt, req_data});
    @(posedge clk);
    #1;
    if (!rst && display_en) begin
      chk("en_one_cycle", 64'(prev_en), 64'd0);
      chk("sb_avail", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        ent = exp_q.pop_front();
        chk("sb_entry", 64'({format_sel, data_in}), 64'(ent));
      end
    end
    prev_en = display_en;
  endtask

  initial begin
    t3_data[0] = 32'd987654321; t3_fmt[0] = 2'b01;
    t3_data[1] = 32'hAACCF0AA;  t3_fmt[1] = 2'b10;
    t3_data[2] = 32'h48656C6F;  t3_fmt[2] = 2'b11;
    rst = 1'b1; req_valid = 1'b0; req_data = 32'd0; req_fmt = 2'b00; display_busy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_en", 64'(display_en), 64'd0);
    chk("rst_data", 64'(data_in), 64'd0);
    chk("rst_fmt", 64'(format_sel), 64'd0);
    chk("rst_issued", 64'(issued_cnt), 64'd0);
    chk("rst_terr", 64'(timeout_err), 64'd0);

    // Single request: the pulse appears two cycles after acceptance.
    req_valid = 1'b1; req_data = 32'hABCD1234; req_fmt = 2'b00;
    tick();
    req_valid = 1'b0;
    chk("t1_en_early", 64'(display_en), 64'd0);
    chk("t1_level", 64'(level), 64'd1);
    tick();
    chk("t1_en", 64'(display_en), 64'd1);
    chk("t1_data", 64'(data_in), 64'hABCD1234);
    chk("t1_fmt", 64'(format_sel), 64'd0);
    display_busy = 1'b1;
    tick();
    chk("t1_en_off", 64'(display_en), 64'd0);
    chk("t1_issued", 64'(issued_cnt), 64'd1);
    tick(); tick();
    display_busy = 1'b0;
    tick(); tick();
    chk("t1_terr", 64'(timeout_err), 64'd0);

    // Three requests; busy already high while idle and on entry to WAIT_ACK.
    display_busy = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_data = t3_data[i]; req_fmt = t3_fmt[i];
      tick();
    end
    req_valid = 1'b0;
    chk("t3_level", 64'(level), 64'd2);
    chk("t3_issued", 64'(issued_cnt), 64'd2);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) begin
        tick();
        chk("t3_stable_data", 64'(data_in), 64'(t3_data[k]));
        chk("t3_stable_fmt", 64'(format_sel), 64'(t3_fmt[k]));
      end
      display_busy = 1'b0;
      tick();
      chk("t3_gap1", 64'(display_en), 64'd0);
      tick();
      chk("t3_gap2", 64'(display_en), (k < 2) ? 64'd1 : 64'd0);
      if (k < 2) display_busy = 1'b1;
    end
    chk("t3_issued_end", 64'(issued_cnt), 64'd4);
    chk("t3_level_end", 64'(level), 64'd0);

    // Fill with no acknowledge: one in flight, four queued, the fifth stalls.
    req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_data = 32'h50000000 + 32'(i); req_fmt = 2'(i);
      tick();
    end
    chk("t2_ready_full", 64'(req_ready), 64'd0);
    chk("t2_level_full", 64'(level), 64'd4);
    for (int i = 0; i < 12; i++) tick();
    chk("t2_terr_before", 64'(timeout_err), 64'd0);
    chk("t2_level_hold", 64'(level), 64'd4);
    tick();
    chk("t2_terr_after", 64'(timeout_err), 64'd1);
    tick();
    chk("t4_level_pop", 64'(level), 64'd3);
    chk("t4_en", 64'(display_en), 64'd1);
    chk("t4_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b0;

    // Reset in WAIT_DONE with three queued discards everything.
    display_busy = 1'b1;
    tick(); tick(); tick();
    chk("t5_level_pre", 64'(level), 64'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0; display_busy = 1'b0;
    chk("t5_level", 64'(level), 64'd0);
    chk("t5_ready", 64'(req_ready), 64'd1);
    chk("t5_issued", 64'(issued_cnt), 64'd0);
    chk("t5_terr", 64'(timeout_err), 64'd0);
    chk("t5_data", 64'(data_in), 64'd0);
    en_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      en_seen = en_seen | display_en;
    end
    chk("t5_no_en", 64'(en_seen), 64'd0);

    // Counter wrap via backdoor preload; FIFO order must be unaffected.
    dut.issued_cnt_r = 16'hFFFE;
    chk("t6_preload", 64'(issued_cnt), 64'hFFFE);
    display_busy = 1'b1;
    req_valid = 1'b1; req_data = 32'hCAFE0001; req_fmt = 2'b11;
    tick();
    req_data = 32'hCAFE0002; req_fmt = 2'b01;
    tick();
    req_valid = 1'b0;
    chk("t6_en_first", 64'(display_en), 64'd1);
    tick();
    chk("t6_cnt_ffff", 64'(issued_cnt), 64'hFFFF);
    tick();
    display_busy = 1'b0;
    tick();
    display_busy = 1'b1;
    tick();
    chk("t6_en_second", 64'(display_en), 64'd1);
    tick();
    chk("t6_cnt_wrap", 64'(issued_cnt), 64'd0);
    tick();
    display_busy = 1'b0;
    tick(); tick();
    chk("t6_level", 64'(level), 64'd0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
